// File: rtl/latch_sample_debouncer_pkg.sv
// Shared definitions for the latch sampling/debounce stage and its neighbours.
// Default parameter values live here so the latch bench and later stages stay in step.
package latch_sample_debouncer_pkg;

    localparam int unsigned DefaultSyncStages   = 2;
    localparam int unsigned DefaultStableCycles = 4;
    localparam int unsigned DefaultCntW         = 8;

    typedef enum logic {
        StStable  = 1'b0,
        StConfirm = 1'b1
    } dbnc_state_e;

endpackage

// File: rtl/latch_sample_debouncer_bit_sync_chain.sv
// Multi-flop synchroniser bringing an asynchronous bit into the clk domain.
// Shifts every cycle; only reset clears it.
module bit_sync_chain
    import latch_sample_debouncer_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DefaultSyncStages
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/latch_sample_debouncer.sv
// Debounces the latched bit: synchronise, require STABLE_CYCLES agreeing samples,
// then emit a clean level, one-cycle edge pulses and a saturating rise counter.
module latch_sample_debouncer
    import latch_sample_debouncer_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = DefaultSyncStages,
    parameter int unsigned STABLE_CYCLES = DefaultStableCycles,
    parameter int unsigned CNT_W         = DefaultCntW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             enable,
    input  logic             clear_count,
    output logic             dout_stable,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] edge_count,
    output logic             count_sat
);

    localparam int unsigned         CntBits = $clog2(STABLE_CYCLES + 1);
    localparam logic [CntBits-1:0]  CntLast = CntBits'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    EdgeMax = '1;

    logic s;

    bit_sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (din),
        .q    (s)
    );

    dbnc_state_e        state_q, state_d;
    logic [CntBits-1:0] cnt_q, cnt_d;
    logic               stable_q, stable_d;
    logic               rise_q, rise_d;
    logic               fall_q, fall_d;
    logic [CNT_W-1:0]   edges_q, edges_d;
    logic               accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StStable;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            edges_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            edges_q  <= edges_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        accept   = 1'b0;
        if (enable) begin
            unique case (state_q)
                StStable: begin
                    cnt_d = '0;
                    if (s != stable_q) begin
                        // A single disagreeing sample suffices when STABLE_CYCLES is 1.
                        if (CntLast == '0) begin
                            accept = 1'b1;
                        end else begin
                            state_d = StConfirm;
                            cnt_d   = CntBits'(1);
                        end
                    end
                end
                StConfirm: begin
                    if (s == stable_q) begin
                        state_d = StStable;
                        cnt_d   = '0;
                    end else if (cnt_q == CntLast) begin
                        accept = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            endcase
            if (accept) begin
                stable_d = s;
                rise_d   = s;
                fall_d   = ~s;
                cnt_d    = '0;
                state_d  = StStable;
            end
        end
    end

    // Clear takes priority over a coincident qualified rise.
    always_comb begin
        edges_d = edges_q;
        if (clear_count) begin
            edges_d = '0;
        end else if (rise_d && (edges_q != EdgeMax)) begin
            edges_d = edges_q + 1'b1;
        end
    end

    always_comb begin
        dout_stable = stable_q;
        rise_pulse  = rise_q;
        fall_pulse  = fall_q;
        edge_count  = edges_q;
        count_sat   = (edges_q == EdgeMax);
    end

endmodule

// File: tb/tb_latch_sample_debouncer.sv
// Directed bench for latch_sample_debouncer: a vector table for the default instance
// plus a hand-written saturation sequence on a 2-bit counter instance.
module tb_latch_sample_debouncer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, din, enable, clear_count;
    logic       dout_stable, rise_pulse, fall_pulse, count_sat;
    logic [7:0] edge_count;
    logic       d2_stable, d2_rise, d2_fall, d2_sat;
    logic [1:0] d2_count;

    latch_sample_debouncer dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .enable     (enable),
        .clear_count(clear_count),
        .dout_stable(dout_stable),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .edge_count (edge_count),
        .count_sat  (count_sat)
    );

    latch_sample_debouncer #(
        .CNT_W(2)
    ) dut2 (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .enable     (enable),
        .clear_count(clear_count),
        .dout_stable(d2_stable),
        .rise_pulse (d2_rise),
        .fall_pulse (d2_fall),
        .edge_count (d2_count),
        .count_sat  (d2_sat)
    );

    typedef struct {
        logic rst;
        logic din;
        logic en;
        logic clr;
        logic e_stable;
        logic e_rise;
        logic e_fall;
        int   e_count;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic rst, input logic d, input logic en, input logic clr,
                       input logic st, input logic r, input logic f, input int cnt);
        vec_t v;
        v.rst = rst; v.din = d; v.en = en; v.clr = clr;
        v.e_stable = st; v.e_rise = r; v.e_fall = f; v.e_count = cnt;
        vecs.push_back(v);
    endtask

    task automatic add_n(input int n, input logic rst, input logic d, input logic en,
                         input logic clr, input logic st, input int cnt);
        for (int i = 0; i < n; i++) add(rst, d, en, clr, st, 1'b0, 1'b0, cnt);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [step %0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic d, input logic en, input logic clr);
        reset = rst; din = d; enable = en; clear_count = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; din = 1'b0; enable = 1'b0; clear_count = 1'b0;

        // Reset with din high: everything stays 0.
        add_n(3, 1, 1, 1, 0, 0, 0);
        add_n(2, 0, 0, 1, 0, 0, 0);
        // Clean rise: level and pulse on the 6th posedge.
        add_n(5, 0, 1, 1, 0, 0, 0);
        add(0, 1, 1, 0, 1, 1, 0, 1);
        add(0, 1, 1, 0, 1, 0, 0, 1);
        // Clean fall.
        add_n(5, 0, 0, 1, 0, 1, 1);
        add(0, 0, 1, 0, 0, 0, 1, 1);
        add(0, 0, 1, 0, 0, 0, 0, 1);
        // Glitches of 2 and 3 samples are rejected.
        add_n(2, 0, 1, 1, 0, 0, 1);
        add_n(5, 0, 0, 1, 0, 0, 1);
        add_n(3, 0, 1, 1, 0, 0, 1);
        add_n(6, 0, 0, 1, 0, 0, 1);
        // Excursion of exactly STABLE_CYCLES samples is accepted, then falls back.
        add_n(4, 0, 1, 1, 0, 0, 1);
        add(0, 0, 1, 0, 0, 0, 0, 1);
        add(0, 0, 1, 0, 1, 1, 0, 2);
        add_n(3, 0, 0, 1, 0, 1, 2);
        add(0, 0, 1, 0, 0, 0, 1, 2);
        add(0, 0, 1, 0, 0, 0, 0, 2);
        // Clear coincident with a qualified rise: count 0, pulse still 1.
        add_n(5, 0, 1, 1, 0, 0, 2);
        add(0, 1, 1, 1, 1, 1, 0, 0);
        add(0, 1, 1, 0, 1, 0, 0, 0);
        add_n(5, 0, 0, 1, 0, 1, 0);
        add(0, 0, 1, 0, 0, 0, 1, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0);
        // Enable dropped mid-CONFIRM for 10 cycles, then the remaining count completes.
        add_n(4, 0, 1, 1, 0, 0, 0);
        add_n(10, 0, 1, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 1, 1, 0, 1);
        // Clear honoured while disabled.
        add(0, 1, 0, 1, 1, 0, 0, 0);
        add(0, 1, 1, 0, 1, 0, 0, 0);
        add_n(5, 0, 0, 1, 0, 1, 0);
        add(0, 0, 1, 0, 0, 0, 1, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0);
        // Reset mid-CONFIRM discards the pending rise; full latency restarts afterwards.
        add_n(4, 0, 1, 1, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0, 0);
        add_n(5, 0, 1, 1, 0, 0, 0);
        add(0, 1, 1, 0, 1, 1, 0, 1);
        add(0, 1, 1, 0, 1, 0, 0, 1);

        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].din, vecs[i].en, vecs[i].clr);
            check("dout_stable", i, 32'(dout_stable), 32'(vecs[i].e_stable));
            check("rise_pulse", i, 32'(rise_pulse), 32'(vecs[i].e_rise));
            check("fall_pulse", i, 32'(fall_pulse), 32'(vecs[i].e_fall));
            check("edge_count", i, 32'(edge_count), 32'(vecs[i].e_count));
            check("count_sat", i, 32'(count_sat), 32'(vecs[i].e_count == 255));
        end

        // Saturation on the 2-bit counter: 1,2,3,3,3 with count_sat from the third rise.
        step(1, 0, 1, 0);
        check("sat_reset_count", 0, 32'(d2_count), 0);
        check("sat_reset_flag", 0, 32'(d2_sat), 0);
        for (int k = 1; k <= 5; k++) begin
            for (int c = 0; c < 5; c++) step(0, 1, 1, 0);
            step(0, 1, 1, 0);
            check("sat_rise_pulse", k, 32'(d2_rise), 1);
            check("sat_count", k, 32'(d2_count), (k < 3) ? k : 3);
            check("sat_flag", k, 32'(d2_sat), (k >= 3) ? 1 : 0);
            for (int c = 0; c < 5; c++) step(0, 0, 1, 0);
            step(0, 0, 1, 0);
            check("sat_fall_pulse", k, 32'(d2_fall), 1);
            check("sat_stable_low", k, 32'(d2_stable), 0);
        end
        step(0, 0, 1, 1);
        check("sat_clear_count", 6, 32'(d2_count), 0);
        check("sat_clear_flag", 6, 32'(d2_sat), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/latch_sample_debouncer.md
Name: latch_sample_debouncer

Overview:
- Stage directly downstream of pos_level_latch: consumes the latch's dout as its din input.
- Synchronises the latched bit into the clk domain and qualifies it as stable only after a fixed number of consecutive agreeing samples.
- Emits a clean level, one-cycle rise/fall pulses and a saturating rising-edge counter.
- Filters the random, sub-cycle toggling that the latch passes through while transparent.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the input synchroniser chain (legal range >= 2).
- STABLE_CYCLES, 4, consecutive disagreeing synchronised samples required before dout_stable changes (legal range >= 1).
- CNT_W, 8, width of edge_count.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- din  input  1  latched data bit from pos_level_latch dout; asynchronous to this stage.
- enable  input  1  1 = qualification and counting active.
- clear_count  input  1  synchronous clear of edge_count and count_sat.
- dout_stable  output  1  debounced level.
- rise_pulse  output  1  one-cycle pulse on a qualified 0->1 transition.
- fall_pulse  output  1  one-cycle pulse on a qualified 1->0 transition.
- edge_count  output  CNT_W  number of qualified rising edges.
- count_sat  output  1  edge_count has reached all-ones.

Behaviour:
- Reset, sampled on posedge while reset=1:
  - synchroniser stages, dout_stable, rise_pulse, fall_pulse, edge_count and count_sat all become 0;
  - stability counter becomes 0 and the FSM enters STABLE.
  - Reset mid-qualification discards the pending transition.
- Synchroniser: s = last stage of the SYNC_STAGES chain. The chain shifts every cycle regardless of enable; only reset clears it.
- FSM states:
  - STABLE: s == dout_stable; counter held at 0.
  - CONFIRM: s != dout_stable; counter increments each enabled cycle.
- Transitions, each posedge with enable=1:
  - s == dout_stable: go to STABLE, counter <= 0. Any disagreement that ends early is fully forgotten.
  - s != dout_stable and counter == STABLE_CYCLES-1:
    - dout_stable <= s;
    - rise_pulse <= s, fall_pulse <= ~s for exactly one cycle;
    - counter <= 0, go to STABLE.
  - Otherwise: go to CONFIRM, counter <= counter+1.
- Pulse rule: rise_pulse and fall_pulse are 0 in every other cycle and are never high together.
- enable=0:
  - FSM state, counter, dout_stable and edge_count are frozen.
  - rise_pulse and fall_pulse are forced to 0.
- Latency: din changes between edges and then holds. dout_stable reflects the new value after exactly SYNC_STAGES+STABLE_CYCLES posedges (6 at defaults); the pulse is asserted in the same cycle that dout_stable changes.
- Glitch rejection: any din excursion producing fewer than STABLE_CYCLES consecutive disagreeing s samples yields no change and no pulse.
- Counter width is ceil(log2(STABLE_CYCLES+1)) bits. With STABLE_CYCLES=1, a transition is accepted on the first disagreeing sample.
- edge_count:
  - increments by 1 on each rise_pulse cycle, computed at the same edge the pulse is generated;
  - saturates at 2^CNT_W-1 and never wraps;
  - count_sat = 1 while edge_count is all-ones.
- clear_count:
  - zeroes edge_count and count_sat at the next posedge;
  - when coincident with a rising qualification, clear wins and edge_count = 0;
  - it does not affect dout_stable or the pulses;
  - it is honoured even when enable=0.

Decomposition:
- Shared package holds:
  - the FSM state encoding constants (ST_STABLE=1'b0, ST_CONFIRM=1'b1);
  - default values for SYNC_STAGES, STABLE_CYCLES and CNT_W, for reuse by the latch bench and other stages.
- One natural sub-module: bit_sync_chain (parameter SYNC_STAGES; ports clk, reset, d, q). It is instantiated once.
- Qualification FSM and edge counter stay in the top module.

Test Plan:
- Reset check: assert reset for 3 cycles with din=1 -> all outputs 0 during and immediately after reset.
- Clean rise: din 0->1 and held, enable=1, defaults -> dout_stable=1 exactly 6 posedges later, rise_pulse high for exactly that one cycle, edge_count=1.
- Glitch rejection: din high for 2 cycles then low -> dout_stable stays 0, no pulses, edge_count=0.
- Saturation, CNT_W=2: 5 clean rise/fall cycles -> edge_count sequence 1,2,3,3,3; count_sat=1 from the third rise.
- Clear collision: assert clear_count in the same cycle as a qualified rise -> edge_count=0, rise_pulse still 1.
- Enable and mid-operation reset:
  - deassert enable during CONFIRM for 10 cycles, then reassert -> no pulse while disabled;
  - the transition completes after the remaining count;
  - reset pulsed mid-CONFIRM -> the pending transition is discarded and outputs return to 0.
